// File: rtl/wb_sram_linefetch.sv
// wb_sram_linefetch: read-only Wishbone master that streams a block of
// SRAM words into a small first-word-fall-through FIFO for a consumer.

module wb_sram_linefetch_fifo #(
    parameter int AW = 4,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          empty,
    output logic [AW:0]   level,
    output logic [AW:0]   level_nxt
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0] LVL_ONE = (AW + 1)'(1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (level == '0);
    assign full    = level[AW];
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    // Head word is exposed directly; gated so an empty FIFO reads as zero.
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_comb begin
        level_nxt = level;
        unique case ({push_ok, pop_ok})
            2'b10:   level_nxt = level + LVL_ONE;
            2'b01:   level_nxt = level - LVL_ONE;
            default: level_nxt = level;
        endcase
        if (flush) level_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            level <= level_nxt;
        end
    end
endmodule

module wb_sram_linefetch #(
    parameter int FIFO_AW = 4
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [17:0]        base_adr_i,
    input  logic [9:0]         len_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [17:0]        wbm_adr_o,
    input  logic [15:0]        wbm_dat_i,
    output logic               wbm_we_o,
    output logic [1:0]         wbm_sel_o,
    output logic               wbm_stb_o,
    output logic               wbm_cyc_o,
    input  logic               wbm_ack_i,
    input  logic               rd_i,
    output logic [15:0]        dat_o,
    output logic               empty_o,
    output logic [FIFO_AW:0]   level_o
);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_FETCH = 1'b1;
    localparam logic [FIFO_AW:0] DEPTH = {1'b1, {FIFO_AW{1'b0}}};

    logic [0:0]       state;
    logic [9:0]       rem;
    logic [9:0]       rem_nxt;
    logic             start_ok;
    logic             run;
    logic             ack_ok;
    logic             last_ack;
    logic             flush;
    logic             pop;
    logic [FIFO_AW:0] level_nxt;

    assign start_ok = start_i & ~abort_i & (state == S_IDLE);
    assign run      = (state == S_FETCH) & ~abort_i;
    // An ack landing in the abort cycle is dropped here.
    assign ack_ok   = run & wbm_stb_o & wbm_ack_i;
    assign last_ack = ack_ok & (rem == 10'd1);
    assign rem_nxt  = ack_ok ? rem - 10'd1 : rem;
    assign flush    = abort_i | start_ok;
    assign pop      = rd_i & ~flush;

    assign busy_o    = (state == S_FETCH);
    assign wbm_cyc_o = wbm_stb_o;
    assign wbm_we_o  = 1'b0;
    assign wbm_sel_o = 2'b11;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= S_IDLE;
            wbm_stb_o <= 1'b0;
            wbm_adr_o <= '0;
            rem       <= '0;
            done_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            unique case (1'b1)
                abort_i: begin
                    state     <= S_IDLE;
                    wbm_stb_o <= 1'b0;
                end
                start_ok: begin
                    wbm_adr_o <= base_adr_i;
                    rem       <= len_i;
                    if (len_i == '0) begin
                        done_o <= 1'b1;
                    end else begin
                        state     <= S_FETCH;
                        wbm_stb_o <= 1'b1;
                    end
                end
                run: begin
                    if (ack_ok) wbm_adr_o <= wbm_adr_o + 18'd1;
                    rem <= rem_nxt;
                    if (last_ack) begin
                        state     <= S_IDLE;
                        wbm_stb_o <= 1'b0;
                        done_o    <= 1'b1;
                    end else begin
                        // Only request when the word will have a slot to land in.
                        wbm_stb_o <= (rem_nxt != '0) && (level_nxt != DEPTH);
                    end
                end
                default: ;
            endcase
        end
    end

    wb_sram_linefetch_fifo #(
        .AW (FIFO_AW),
        .DW (16)
    ) u_fifo (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .flush     (flush),
        .push      (ack_ok),
        .wdata     (wbm_dat_i),
        .pop       (pop),
        .rdata     (dat_o),
        .empty     (empty_o),
        .level     (level_o),
        .level_nxt (level_nxt)
    );
endmodule

// File: tb/tb_wb_sram_linefetch.sv
// tb_wb_sram_linefetch: randomized and table-driven check of the line
// fetcher against a queue-based model of the expected word stream.

module tb_wb_sram_linefetch;
    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [17:0] base_adr;
    logic [9:0]  len;
    logic        busy;
    logic        done;
    logic [17:0] adr;
    logic [15:0] wbm_dat;
    logic        we;
    logic [1:0]  sel;
    logic        stb;
    logic        cyc;
    logic        wbm_ack;
    logic        rd;
    logic [15:0] dat;
    logic        empty;
    logic [4:0]  level;

    int checks = 0;
    int errors = 0;
    int ack_mode = 0;
    int pop_mode = 0;
    logic hold = 1'b0;
    int acc_cnt = 0;
    int pop_cnt = 0;
    int done_cnt = 0;

    typedef struct {
        logic [17:0] base;
        logic [9:0]  len;
        int          ackm;
        int          popm;
        int          exp_words;
    } vec_t;

    vec_t vecs[8];

    wb_sram_linefetch #(.FIFO_AW(4)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .start_i    (start),
        .abort_i    (abort),
        .base_adr_i (base_adr),
        .len_i      (len),
        .busy_o     (busy),
        .done_o     (done),
        .wbm_adr_o  (adr),
        .wbm_dat_i  (wbm_dat),
        .wbm_we_o   (we),
        .wbm_sel_o  (sel),
        .wbm_stb_o  (stb),
        .wbm_cyc_o  (cyc),
        .wbm_ack_i  (wbm_ack),
        .rd_i       (rd),
        .dat_o      (dat),
        .empty_o    (empty),
        .level_o    (level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] word_of(input logic [17:0] a);
        return {a[7:0], a[15:8]} ^ {14'b0, a[17:16]} ^ 16'h5A3C;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory-side slave and consumer, driven on the falling edge.
    always @(negedge clk) begin
        case (ack_mode)
            0:       wbm_ack = stb && !wbm_ack;
            1:       wbm_ack = ($urandom_range(0, 2) == 0);
            default: wbm_ack = stb;
        endcase
        if (hold || rst) wbm_ack = 1'b0;
        wbm_dat = wbm_ack ? word_of(adr) : 16'($urandom);
        case (pop_mode)
            0: rd = 1'b0;
            1: rd = 1'b1;
            2: rd = ($urandom_range(0, 1) == 1);
            default: begin
                rd = 1'b1;
                pop_mode = 0;
            end
        endcase
    end

    logic [15:0] q[$];
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [17:0] m_adr = '0;
    int          m_rem = 0;
    logic        s_stb = 1'b0;
    logic        s_empty = 1'b1;

    always @(posedge clk) begin
        logic        p_rst;
        logic        p_abort;
        logic        p_start;
        logic        p_ack;
        logic        p_rd;
        logic [17:0] p_base;
        logic [9:0]  p_len;
        p_rst   = rst;
        p_abort = abort;
        p_start = start;
        p_ack   = wbm_ack && s_stb;
        p_rd    = rd;
        p_base  = base_adr;
        p_len   = len;
        m_done  = 1'b0;
        if (p_rst) begin
            q.delete();
            m_busy = 1'b0;
            m_adr  = '0;
        end else if (p_abort) begin
            q.delete();
            m_busy = 1'b0;
        end else if (!m_busy && p_start) begin
            q.delete();
            if (p_len == 0) begin
                m_done = 1'b1;
            end else begin
                m_busy = 1'b1;
                m_adr  = p_base;
                m_rem  = int'(p_len);
            end
        end else begin
            if (p_rd && !s_empty) pop_cnt++;
            if (p_rd && q.size() > 0) void'(q.pop_front());
            if (m_busy && p_ack) begin
                chk("ack_adr", 32'(adr), 32'(m_adr));
                q.push_back(word_of(m_adr));
                acc_cnt++;
                m_adr = m_adr + 18'd1;
                m_rem--;
                if (m_rem == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
        #1;
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        if (done) done_cnt++;
        chk("stb", 32'(stb), 32'(m_busy && q.size() < 16));
        chk("cyc", 32'(cyc), 32'(m_busy && q.size() < 16));
        chk("we_sel", {29'b0, we, sel}, 32'h3);
        if (m_busy && q.size() < 16) chk("adr", 32'(adr), 32'(m_adr));
        if (p_rst) begin
            chk("rst_adr", 32'(adr), 32'h0);
            chk("rst_dat", 32'(dat), 32'h0);
        end
        chk("level", 32'(level), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        if (q.size() > 0) chk("dat", 32'(dat), 32'(q[0]));
        s_stb   = stb;
        s_empty = empty;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_start(input logic [17:0] b, input logic [9:0] l);
        base_adr = b;
        len = l;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max, input string nm);
        int n = 0;
        while (busy && n < max) begin
            tick();
            n++;
        end
        chk(nm, 32'(busy), 32'h0);
    endtask

    task automatic drain();
        int n = 0;
        pop_mode = 1;
        while (!empty && n < 200) begin
            tick();
            n++;
        end
        chk("drain_empty", 32'(empty), 32'h1);
        pop_mode = 0;
        tick();
    endtask

    task automatic clr_cnt();
        acc_cnt = 0;
        pop_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic run_vec(input vec_t v);
        clr_cnt();
        ack_mode = v.ackm;
        pop_mode = v.popm;
        do_start(v.base, v.len);
        wait_idle(4000, "vec_idle");
        drain();
        chk("vec_words", 32'(pop_cnt), 32'(v.exp_words));
        chk("vec_done", 32'(done_cnt), 32'h1);
    endtask

    initial begin
        vec_t v;
        int n;
        vecs[0] = '{18'h00100, 10'd4, 0, 1, 4};
        vecs[1] = '{18'h3FFFE, 10'd4, 0, 1, 4};
        vecs[2] = '{18'h00000, 10'd0, 0, 1, 0};
        vecs[3] = '{18'h12345, 10'd17, 2, 2, 17};
        vecs[4] = '{18'h20000, 10'd33, 1, 2, 33};
        vecs[5] = '{18'h3FFF0, 10'd40, 1, 2, 40};
        vecs[6] = '{18'h00ABC, 10'd16, 2, 0, 16};
        vecs[7] = '{18'h1F000, 10'd1023, 2, 1, 1023};

        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        base_adr = '0;
        len = '0;
        wbm_ack = 1'b0;
        wbm_dat = '0;
        rd = 1'b0;
        repeat (3) tick();
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_level", 32'(level), 32'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        for (int i = 0; i < 12; i++) begin
            v.base = 18'($urandom);
            v.len = 10'($urandom_range(1, 60));
            v.ackm = 1;
            v.popm = 2;
            v.exp_words = int'(v.len);
            run_vec(v);
        end

        // Back-pressure: fill, single pop, then drain.
        clr_cnt();
        ack_mode = 0;
        pop_mode = 0;
        do_start(18'h01000, 10'd20);
        n = 0;
        while (level != 5'd16 && n < 300) begin
            tick();
            n++;
        end
        repeat (4) tick();
        chk("bp_level", 32'(level), 32'd16);
        chk("bp_stb", 32'(stb), 32'h0);
        chk("bp_acc", 32'(acc_cnt), 32'd16);
        pop_mode = 3;
        tick();
        repeat (10) tick();
        chk("bp_acc1", 32'(acc_cnt), 32'd17);
        chk("bp_level1", 32'(level), 32'd16);
        pop_mode = 1;
        wait_idle(500, "bp_idle");
        drain();
        chk("bp_words", 32'(pop_cnt), 32'd20);
        chk("bp_done", 32'(done_cnt), 32'h1);

        // Contention: acks withheld mid-fetch; a start while busy is ignored.
        clr_cnt();
        ack_mode = 0;
        pop_mode = 1;
        do_start(18'h2AAA0, 10'd8);
        n = 0;
        while (acc_cnt < 3 && n < 100) begin
            tick();
            n++;
        end
        hold = 1'b1;
        repeat (2) tick();
        do_start(18'h00005, 10'd3);
        for (int i = 0; i < 10; i++) begin
            chk("hold_adr", 32'(adr), 32'(18'h2AAA0 + 18'(acc_cnt)));
            chk("hold_stb", 32'(stb), 32'h1);
            tick();
        end
        hold = 1'b0;
        wait_idle(500, "hold_idle");
        drain();
        chk("hold_words", 32'(pop_cnt), 32'd8);
        chk("hold_done", 32'(done_cnt), 32'h1);

        // Abort coincident with the third ack.
        clr_cnt();
        ack_mode = 0;
        pop_mode = 0;
        do_start(18'h00400, 10'd8);
        n = 0;
        while (!(wbm_ack && stb && acc_cnt == 2) && n < 100) begin
            tick();
            n++;
        end
        chk("ab_found", 32'(n < 100), 32'h1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_stb", 32'(stb), 32'h0);
        chk("ab_empty", 32'(empty), 32'h1);
        chk("ab_busy", 32'(busy), 32'h0);
        repeat (3) tick();
        chk("ab_done", 32'(done_cnt), 32'h0);
        v = '{18'h00777, 10'd8, 0, 1, 8};
        run_vec(v);

        // Reset in the middle of a fetch.
        ack_mode = 0;
        pop_mode = 0;
        do_start(18'h03000, 10'd30);
        repeat (8) tick();
        rst = 1'b1;
        tick();
        chk("mr_stb", 32'(stb), 32'h0);
        chk("mr_cyc", 32'(cyc), 32'h0);
        chk("mr_adr", 32'(adr), 32'h0);
        chk("mr_busy", 32'(busy), 32'h0);
        chk("mr_done", 32'(done), 32'h0);
        chk("mr_empty", 32'(empty), 32'h1);
        chk("mr_level", 32'(level), 32'h0);
        chk("mr_dat", 32'(dat), 32'h0);
        rst = 1'b0;
        tick();
        v = '{18'h3FFFD, 10'd5, 1, 2, 5};
        run_vec(v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
